// File: rtl/spi_master_phy_if.sv
// Command-side bundle between the UART command controller and the SPI PHY.
// Latency: n/a (wires only).
// Backpressure: spi_data_valid low means busy; spi_start is ignored until it returns high.
interface spi_master_phy_if #(
    parameter int SPI_ADDR_WIDTH = 6,
    parameter int SPI_DATA_WIDTH = 20
);
    logic                      spi_start;
    logic                      spi_rw;
    logic [SPI_ADDR_WIDTH-1:0] spi_write_address;
    logic [SPI_DATA_WIDTH-1:0] spi_write_data;
    logic [SPI_DATA_WIDTH-1:0] spi_read_data;
    logic                      spi_data_valid;

    // Controller side drives the request and consumes the result.
    modport master (
        output spi_start, spi_rw, spi_write_address, spi_write_data,
        input  spi_read_data, spi_data_valid
    );

    // PHY side consumes the request and returns the result.
    modport slave (
        input  spi_start, spi_rw, spi_write_address, spi_write_data,
        output spi_read_data, spi_data_valid
    );
endinterface

// File: rtl/spi_master_phy.sv
// SPI mode-0 master: one {rw, addr, data} frame per request, MSB first, read data sampled in data phase.
// Latency: valid returns (2*FRAME+3)*CLK_DIV+1 cycles after the start-sample cycle.
// Backpressure: start is sampled only in IDLE (valid high); requests while busy are dropped.
module spi_master_phy #(
    parameter int SPI_ADDR_WIDTH = 6,
    parameter int SPI_DATA_WIDTH = 20,
    parameter int CLK_DIV        = 4
) (
    input  logic                 i_clk_sys,
    input  logic                 i_rst_n,
    spi_master_phy_if.slave      io_cmd,
    output logic                 o_spi_sclk,
    output logic                 o_spi_cs_n,
    output logic                 o_spi_mosi,
    input  logic                 i_spi_miso
);
    localparam int FRAME = 1 + SPI_ADDR_WIDTH + SPI_DATA_WIDTH;
    localparam int DIVW  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BITW  = $clog2(2 * FRAME + 1);
    localparam logic [DIVW-1:0] DIV_LAST      = DIVW'(CLK_DIV - 1);
    localparam logic [BITW-1:0] BIT_LAST      = BITW'(2 * FRAME);
    // First half-period whose rising edge carries a data bit (rise k = AW+2).
    localparam logic [BITW-1:0] FIRST_RD_HALF = BITW'(2 * SPI_ADDR_WIDTH + 3);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t                    r_state, w_state;
    logic [DIVW-1:0]           r_div,   w_div;
    logic [BITW-1:0]           r_bit,   w_bit;
    logic [FRAME-1:0]          r_tx,    w_tx;
    logic [SPI_DATA_WIDTH-1:0] r_rx,    w_rx;
    logic [SPI_DATA_WIDTH-1:0] r_rdata, w_rdata;
    logic                      r_rw,    w_rw;
    logic                      r_valid, w_valid;
    logic                      r_sclk,  w_sclk;
    logic                      r_cs_n,  w_cs_n;
    logic                      r_mosi,  w_mosi;
    logic [BITW-1:0]           w_bit_inc;

    assign w_bit_inc = r_bit + 1'b1;

    // State and datapath registers; synchronous reset returns everything to idle values.
    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_rdata <= '0;
            r_rw    <= 1'b0;
            r_valid <= 1'b1;
            r_sclk  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_bit   <= w_bit;
            r_tx    <= w_tx;
            r_rx    <= w_rx;
            r_rdata <= w_rdata;
            r_rw    <= w_rw;
            r_valid <= w_valid;
            r_sclk  <= w_sclk;
            r_cs_n  <= w_cs_n;
            r_mosi  <= w_mosi;
        end
    end

    // Next-state and next-output logic; every register holds unless its phase updates it.
    always_comb begin
        w_state = r_state;
        w_div   = r_div;
        w_bit   = r_bit;
        w_tx    = r_tx;
        w_rx    = r_rx;
        w_rdata = r_rdata;
        w_rw    = r_rw;
        w_valid = r_valid;
        w_sclk  = r_sclk;
        w_cs_n  = r_cs_n;
        w_mosi  = r_mosi;
        case (r_state)
            S_IDLE: begin
                if (io_cmd.spi_start) begin
                    w_tx    = {io_cmd.spi_rw, io_cmd.spi_write_address, io_cmd.spi_write_data};
                    w_rw    = io_cmd.spi_rw;
                    w_mosi  = io_cmd.spi_rw;
                    w_cs_n  = 1'b0;
                    w_valid = 1'b0;
                    w_div   = '0;
                    w_bit   = '0;
                    w_state = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_div == DIV_LAST) begin
                    // Entering half-period 1: first rising edge (rw bit, never captured).
                    w_div   = '0;
                    w_bit   = BITW'(1);
                    w_sclk  = 1'b1;
                    w_state = S_SHIFT;
                end else begin
                    w_div = r_div + 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_div == DIV_LAST) begin
                    w_div = '0;
                    if (r_bit == BIT_LAST) begin
                        w_state = S_HOLD;
                        if (r_rw) begin
                            w_rdata = r_rx;
                        end
                    end else begin
                        w_bit = w_bit_inc;
                        if (w_bit_inc[0]) begin
                            w_sclk = 1'b1;
                            if (r_rw && (w_bit_inc >= FIRST_RD_HALF)) begin
                                w_rx = {r_rx[SPI_DATA_WIDTH-2:0], i_spi_miso};
                            end
                        end else begin
                            // Zero shifted in at the LSB leaves mosi low after the last bit.
                            w_sclk = 1'b0;
                            w_mosi = r_tx[FRAME-2];
                            w_tx   = {r_tx[FRAME-2:0], 1'b0};
                        end
                    end
                end else begin
                    w_div = r_div + 1'b1;
                end
            end
            S_HOLD: begin
                if (r_div == DIV_LAST) begin
                    w_div   = '0;
                    w_cs_n  = 1'b1;
                    w_state = S_GAP;
                end else begin
                    w_div = r_div + 1'b1;
                end
            end
            S_GAP: begin
                if (r_div == DIV_LAST) begin
                    w_div   = '0;
                    w_valid = 1'b1;
                    w_state = S_IDLE;
                end else begin
                    w_div = r_div + 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_div   = '0;
                w_bit   = '0;
                w_tx    = '0;
                w_rx    = '0;
                w_rdata = '0;
                w_rw    = 1'b0;
                w_valid = 1'b1;
                w_sclk  = 1'b0;
                w_cs_n  = 1'b1;
                w_mosi  = 1'b0;
            end
        endcase
    end

    assign o_spi_sclk            = r_sclk;
    assign o_spi_cs_n            = r_cs_n;
    assign o_spi_mosi            = r_mosi;
    assign io_cmd.spi_read_data  = r_rdata;
    assign io_cmd.spi_data_valid = r_valid;
endmodule

// File: tb/tb_spi_master_phy.sv
// Randomised scoreboard bench for spi_master_phy: frame content, read data, latency, busy, reset.
module tb_spi_master_phy;
    localparam int AW   = 6;
    localparam int DW   = 20;
    localparam int DIV  = 4;
    localparam int F    = 1 + AW + DW;
    localparam int LAT  = (2 * F + 3) * DIV + 1;
    localparam int DIV2 = 2;
    localparam int LAT2 = (2 * F + 3) * DIV2 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst2_n;
    logic sclk, cs_n, mosi, miso;
    logic sclk2, cs2_n, mosi2, miso2;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_phy_if #(.SPI_ADDR_WIDTH(AW), .SPI_DATA_WIDTH(DW)) cmd ();
    spi_master_phy_if #(.SPI_ADDR_WIDTH(AW), .SPI_DATA_WIDTH(DW)) cmd2 ();

    spi_master_phy #(.SPI_ADDR_WIDTH(AW), .SPI_DATA_WIDTH(DW), .CLK_DIV(DIV)) dut (
        .i_clk_sys(clk), .i_rst_n(rst_n), .io_cmd(cmd),
        .o_spi_sclk(sclk), .o_spi_cs_n(cs_n), .o_spi_mosi(mosi), .i_spi_miso(miso)
    );

    spi_master_phy #(.SPI_ADDR_WIDTH(AW), .SPI_DATA_WIDTH(DW), .CLK_DIV(DIV2)) dut2 (
        .i_clk_sys(clk), .i_rst_n(rst2_n), .io_cmd(cmd2),
        .o_spi_sclk(sclk2), .o_spi_cs_n(cs2_n), .o_spi_mosi(mosi2), .i_spi_miso(miso2)
    );

    typedef struct {
        logic [F-1:0]  frame;
        logic [DW-1:0] miso_word;
        logic [DW-1:0] old_rdata;
        logic [DW-1:0] rdata;
        int            t_start;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] m_rdata;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor: SPI slave model + scoreboard ----------------
    exp_t         cur;
    int           m_rises;
    logic [F-1:0] m_bits;
    logic         p_sclk, p_valid, p_cs;

    initial begin
        m_rises = 0; m_bits = '0; p_sclk = 1'b0; p_valid = 1'b1; p_cs = 1'b1; miso = 1'b1;
        cur = '{default: '0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_rises = 0; p_sclk = 1'b0; p_valid = 1'b1; p_cs = 1'b1; miso = 1'b1;
            end else begin
                if (p_cs && !cs_n) begin
                    m_rises = 0;
                    m_bits  = '0;
                    miso    = 1'b1;
                    check("frame_expected", 64'(sbq.size() != 0), 64'd1);
                    if (sbq.size() != 0) cur = sbq[0];
                end
                if (!p_sclk && sclk) begin
                    int k;
                    m_rises++;
                    m_bits = {m_bits[F-2:0], mosi};
                    if (m_rises == F) check("rdata_no_partial", 64'(cmd.spi_read_data), 64'(cur.old_rdata));
                    k = m_rises + 1;
                    if (k <= 1 + AW || k > F) miso = 1'b1;
                    else miso = cur.miso_word[DW - 1 - (k - AW - 2)];
                end
                if (!p_valid && cmd.spi_data_valid) begin
                    check("valid_expected", 64'(sbq.size() != 0), 64'd1);
                    if (sbq.size() != 0) begin
                        exp_t e;
                        e = sbq.pop_front();
                        check("mosi_frame", 64'(m_bits), 64'(e.frame));
                        check("sclk_pulses", 64'(m_rises), 64'(F));
                        check("read_data", 64'(cmd.spi_read_data), 64'(e.rdata));
                        check("latency", 64'(cyc - e.t_start + 1), 64'(LAT));
                        check("mosi_idle", 64'(mosi), 64'd0);
                    end
                end
                p_sclk  = sclk;
                p_valid = cmd.spi_data_valid;
                p_cs    = cs_n;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        int n = 0;
        while (!cmd.spi_data_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(n < 2000), 64'd1);
    endtask

    task automatic issue(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] mw, input bit poke, input bit track_rdata);
        exp_t e;
        wait_idle();
        @(negedge clk);
        e.frame     = {rw, a, d};
        e.miso_word = mw;
        e.old_rdata = m_rdata;
        if (rw && track_rdata) m_rdata = mw;
        e.rdata     = m_rdata;
        e.t_start   = cyc + 1;
        sbq.push_back(e);
        cmd.spi_start = 1'b1; cmd.spi_rw = rw; cmd.spi_write_address = a; cmd.spi_write_data = d;
        @(negedge clk);
        // Inputs change after the sample cycle; the latched frame must not follow them.
        cmd.spi_start = 1'b0; cmd.spi_rw = ~rw;
        cmd.spi_write_address = AW'($urandom); cmd.spi_write_data = DW'($urandom);
        if (poke) begin
            repeat (48) @(negedge clk);
            cmd.spi_start = 1'b1; cmd.spi_write_address = ~a; cmd.spi_rw = ~rw;
            repeat (2) @(negedge clk);
            cmd.spi_start = 1'b0;
        end
    endtask

    initial begin
        int n, nfalls, last_fall, last_rise, pulses;
        logic pc, ps;
        rst_n = 1'b0; rst2_n = 1'b0; m_rdata = '0;
        cmd.spi_start = 1'b0; cmd.spi_rw = 1'b0; cmd.spi_write_address = '0; cmd.spi_write_data = '0;
        cmd2.spi_start = 1'b0; cmd2.spi_rw = 1'b0; cmd2.spi_write_address = '0; cmd2.spi_write_data = '0;
        miso2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", 64'(cs_n), 64'd1);
        check("rst_sclk", 64'(sclk), 64'd0);
        check("rst_mosi", 64'(mosi), 64'd0);
        check("rst_valid", 64'(cmd.spi_data_valid), 64'd1);
        check("rst_rdata", 64'(cmd.spi_read_data), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        issue(1'b0, 6'h2A, 20'hABCDE, 20'h0, 1'b0, 1'b1);
        issue(1'b1, 6'h05, 20'h0, 20'h12345, 1'b0, 1'b1);
        issue(1'b0, AW'($urandom), DW'($urandom), DW'($urandom), 1'b1, 1'b1);
        issue(1'b1, AW'($urandom), DW'($urandom), DW'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < 6; i++)
            issue(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), DW'($urandom), 1'b0, 1'b1);

        // Reset in the middle of a read frame.
        issue(1'b1, AW'($urandom), DW'($urandom), DW'($urandom), 1'b0, 1'b0);
        n = 0;
        while (m_rises < 10 && n < 2000) begin @(negedge clk); n++; end
        check("rise10_timeout", 64'(n < 2000), 64'd1);
        void'(sbq.pop_back());
        @(posedge clk); #1 rst_n = 1'b0;
        #1 check("rst_is_sync", 64'(cs_n), 64'd0);
        @(posedge clk); #1;
        check("midrst_cs_n", 64'(cs_n), 64'd1);
        check("midrst_sclk", 64'(sclk), 64'd0);
        check("midrst_mosi", 64'(mosi), 64'd0);
        check("midrst_valid", 64'(cmd.spi_data_valid), 64'd1);
        check("midrst_rdata", 64'(cmd.spi_read_data), 64'd0);
        m_rdata = '0;
        @(negedge clk) rst_n = 1'b1;
        issue(1'b1, AW'($urandom), DW'($urandom), DW'($urandom), 1'b0, 1'b1);
        issue(1'b0, AW'($urandom), DW'($urandom), DW'($urandom), 1'b0, 1'b1);
        wait_idle();
        n = 0;
        while (sbq.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        check("drain_timeout", 64'(n < 2000), 64'd1);

        // Back-to-back frames at CLK_DIV = 2 with start held high.
        @(negedge clk) rst2_n = 1'b1; cmd2.spi_start = 1'b1;
        nfalls = 0; last_fall = 0; last_rise = -1; pulses = 0; pc = 1'b1; ps = 1'b0;
        for (n = 0; n < 5 * LAT2 && nfalls < 4; n++) begin
            @(negedge clk);
            if (!ps && sclk2) pulses++;
            if (!pc && cs2_n) last_rise = n;
            if (pc && !cs2_n) begin
                if (nfalls > 0) begin
                    check("b2b_period", 64'(n - last_fall), 64'(LAT2));
                    check("b2b_cs_high", 64'(n - last_rise), 64'(DIV2 + 1));
                    check("b2b_pulses", 64'(pulses), 64'(F));
                end
                nfalls++; last_fall = n; pulses = 0;
            end
            pc = cs2_n; ps = sclk2;
        end
        check("b2b_frames", 64'(nfalls), 64'd4);
        cmd2.spi_start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
